// File: rtl/addr_reg_pair_if.sv
// Bus bundle for the paired high/low address register: data/address bus
// inputs, command strobes and the register's status/LED outputs.
interface addr_reg_pair_if #(
  parameter int HALF_W = 8
);
  logic [HALF_W-1:0]   data_in;
  logic [2*HALF_W-1:0] addr_in;
  logic                ld_hi;
  logic                ld_lo;
  logic                ld_addr;
  logic                inc;
  logic                sel;
  logic [2*HALF_W-1:0] addr_out;
  logic                addr_oe;
  logic [2*HALF_W-1:0] content;
  logic                busy;
  logic                carry;
  logic                overrun;
  logic                led_ld;
  logic                led_sel;

  modport master (
    output data_in, addr_in, ld_hi, ld_lo, ld_addr, inc, sel,
    input  addr_out, addr_oe, content, busy, carry, overrun, led_ld, led_sel
  );

  modport slave (
    input  data_in, addr_in, ld_hi, ld_lo, ld_addr, inc, sel,
    output addr_out, addr_oe, content, busy, carry, overrun, led_ld, led_sel
  );
endinterface

// File: rtl/addr_reg_pair.sv
// Paired high/low memory-address register with relay-style settle delay:
// half loads from the data bus, full loads from the address bus, increment.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for a command; busy=0
// S_SETTLE | command latched, down-counter runs SETTLE-1..0, commit at 0
module addr_reg_pair #(
  parameter int HALF_W = 8,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst,
  addr_reg_pair_if.slave     bus
);
  localparam int AW = 2 * HALF_W;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SETTLE = 1'b1
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [AW-1:0]   content_q;
  logic [AW-1:0]   pend_val;
  logic            pend_carry;
  logic            carry_q;
  logic            overrun_q;
  logic            busy_q;
  logic            led_q;

  logic            any_cmd;
  logic [AW-1:0]   next_val;
  logic            next_carry;
  logic [AW:0]     inc_sum;

  assign any_cmd = bus.ld_hi | bus.ld_lo | bus.ld_addr | bus.inc;
  assign inc_sum = {1'b0, content_q} + {{AW{1'b0}}, 1'b1};

  // Priority: full-word load, then half loads (both halves may load together),
  // then increment. Lower-priority strobes in the same cycle are dropped.
  always_comb begin
    next_val   = content_q;
    next_carry = 1'b0;
    if (bus.ld_addr) begin
      next_val = bus.addr_in;
    end else if (bus.ld_hi || bus.ld_lo) begin
      if (bus.ld_hi) next_val[AW-1:HALF_W] = bus.data_in;
      if (bus.ld_lo) next_val[HALF_W-1:0]  = bus.data_in;
    end else if (bus.inc) begin
      next_val   = inc_sum[AW-1:0];
      next_carry = inc_sum[AW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      content_q  <= '0;
      pend_val   <= '0;
      pend_carry <= 1'b0;
      carry_q    <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      carry_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_cmd) begin
            pend_val   <= next_val;
            pend_carry <= next_carry;
            cnt        <= CNT_INIT;
            state      <= S_SETTLE;
            busy_q     <= 1'b1;
            led_q      <= 1'b1;
          end
        end
        S_SETTLE: begin
          // Strobes seen here, including on the commit edge, are dropped.
          if (any_cmd) overrun_q <= 1'b1;
          if (cnt == 4'd0) begin
            content_q <= pend_val;
            carry_q   <= pend_carry;
            state     <= S_IDLE;
            busy_q    <= 1'b0;
            led_q     <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          led_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.content  = content_q;
  assign bus.addr_out = bus.sel ? content_q : '0;
  assign bus.addr_oe  = bus.sel;
  assign bus.led_sel  = bus.sel;
  assign bus.busy     = busy_q;
  assign bus.carry    = carry_q;
  assign bus.overrun  = overrun_q;
  assign bus.led_ld   = led_q;
endmodule

// File: tb/tb_addr_reg_pair.sv
// Scoreboard bench for addr_reg_pair (HALF_W=8, SETTLE=2): expected commits
// are queued at stimulus time and popped when busy falls.
module tb_addr_reg_pair;
  localparam int HALF_W = 8;
  localparam int SETTLE = 2;

  typedef struct packed {
    logic [15:0] val;
    logic        cy;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb[$];
  logic [15:0] model_content;

  addr_reg_pair_if #(.HALF_W(HALF_W)) bus ();

  addr_reg_pair #(.HALF_W(HALF_W), .SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_strobes();
    bus.ld_hi   = 1'b0;
    bus.ld_lo   = 1'b0;
    bus.ld_addr = 1'b0;
    bus.inc     = 1'b0;
  endtask

  task automatic do_cmd(input string tag, input logic hi, input logic lo,
                        input logic la, input logic ic, input logic [7:0] d,
                        input logic [15:0] a, input logic [15:0] exp_v,
                        input logic exp_c, input bit poke);
    exp_t e;
    int   cyc;
    logic [15:0] held;
    @(negedge clk);
    bus.ld_hi   = hi;
    bus.ld_lo   = lo;
    bus.ld_addr = la;
    bus.inc     = ic;
    bus.data_in = d;
    bus.addr_in = a;
    e.val = exp_v;
    e.cy  = exp_c;
    sb.push_back(e);
    held = model_content;
    @(posedge clk);
    #1;
    clr_strobes();
    chk({tag, "_busy_acc"}, {31'd0, bus.busy}, 32'd1);
    cyc = 0;
    while (bus.busy && cyc < 40) begin
      chk({tag, "_held"}, {16'd0, bus.content}, {16'd0, held});
      chk({tag, "_aout_busy"}, {16'd0, bus.addr_out}, {16'd0, bus.sel ? held : 16'd0});
      chk({tag, "_led_busy"}, {31'd0, bus.led_ld}, 32'd1);
      if (poke && cyc == 0) begin
        @(negedge clk);
        bus.inc = 1'b1;
      end
      @(posedge clk);
      #1;
      clr_strobes();
      cyc++;
    end
    chk({tag, "_latency"}, cyc, SETTLE);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_content"}, {16'd0, bus.content}, {16'd0, e.val});
      chk({tag, "_carry"}, {31'd0, bus.carry}, {31'd0, e.cy});
      chk({tag, "_aout"}, {16'd0, bus.addr_out}, {16'd0, bus.sel ? e.val : 16'd0});
      chk({tag, "_led_idle"}, {31'd0, bus.led_ld}, 32'd0);
      model_content = e.val;
    end
    @(posedge clk);
    #1;
    chk({tag, "_carry_off"}, {31'd0, bus.carry}, 32'd0);
    chk({tag, "_stay"}, {16'd0, bus.content}, {16'd0, model_content});
  endtask

  initial begin
    rst = 1'b1;
    clr_strobes();
    bus.sel     = 1'b0;
    bus.data_in = '0;
    bus.addr_in = '0;
    model_content = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_content", {16'd0, bus.content}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_carry", {31'd0, bus.carry}, 32'd0);
    chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    chk("rst_led", {31'd0, bus.led_ld}, 32'd0);
    chk("rst_aout", {16'd0, bus.addr_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_cmd("ld_hi", 1, 0, 0, 0, 8'h12, 16'h0, 16'h1200, 1'b0, 0);
    do_cmd("ld_lo", 0, 1, 0, 0, 8'h34, 16'h0, 16'h1234, 1'b0, 0);
    do_cmd("ld_ffff", 0, 0, 1, 0, 8'h00, 16'hFFFF, 16'hFFFF, 1'b0, 0);
    do_cmd("inc_wrap", 0, 0, 0, 1, 8'h00, 16'h0, 16'h0000, 1'b1, 0);
    do_cmd("inc_one", 0, 0, 0, 1, 8'h00, 16'h0, 16'h0001, 1'b0, 0);
    do_cmd("addr_prio", 0, 1, 1, 0, 8'h55, 16'hBEEF, 16'hBEEF, 1'b0, 0);
    chk("prio_overrun", {31'd0, bus.overrun}, 32'd0);
    do_cmd("both_halves", 1, 1, 0, 1, 8'h5A, 16'h0, 16'h5A5A, 1'b0, 0);
    chk("halves_overrun", {31'd0, bus.overrun}, 32'd0);

    do_cmd("ld_1234", 0, 0, 1, 0, 8'h00, 16'h1234, 16'h1234, 1'b0, 0);
    bus.sel = 1'b1;
    #1;
    chk("sel_oe", {31'd0, bus.addr_oe}, 32'd1);
    chk("sel_led", {31'd0, bus.led_sel}, 32'd1);
    do_cmd("sel_a0", 0, 0, 1, 0, 8'h00, 16'h00A0, 16'h00A0, 1'b0, 0);
    @(negedge clk);
    bus.sel = 1'b0;
    #1;
    chk("nosel_aout", {16'd0, bus.addr_out}, 32'd0);
    chk("nosel_oe", {31'd0, bus.addr_oe}, 32'd0);
    chk("nosel_led", {31'd0, bus.led_sel}, 32'd0);

    do_cmd("inc_poke", 0, 0, 0, 1, 8'h00, 16'h0, 16'h00A1, 1'b0, 1);
    chk("poke_overrun", {31'd0, bus.overrun}, 32'd1);
    do_cmd("after_poke", 1, 0, 0, 0, 8'h77, 16'h0, 16'h77A1, 1'b0, 0);
    chk("overrun_sticky", {31'd0, bus.overrun}, 32'd1);

    @(negedge clk);
    bus.ld_addr = 1'b1;
    bus.addr_in = 16'h4321;
    @(posedge clk);
    #1;
    clr_strobes();
    chk("abort_busy_acc", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_content", {16'd0, bus.content}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_overrun", {31'd0, bus.overrun}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_content = 16'h0000;
    repeat (4) @(negedge clk);
    chk("post_rst_content", {16'd0, bus.content}, 32'd0);
    chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("post_rst_led", {31'd0, bus.led_ld}, 32'd0);

    do_cmd("final_inc", 0, 0, 0, 1, 8'h00, 16'h0, 16'h0001, 1'b0, 0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/addr_reg_pair.md
# addr_reg_pair

Parametrised successor to the single-half address register: a paired high/low memory-address register (M1:M2 style) for the relay-computer model. It loads either half from the data bus, loads the full word from the address bus, and increments in place. Every content change takes a configurable settle time, mirroring relay contact closure. It sits between the data bus, the address bus and the control sequencer, and provides LED mirror outputs for the front panel.

## Interface
Parameters:
- HALF_W, default 8 — data-bus width; each half is HALF_W bits, the full address is 2*HALF_W bits.
- SETTLE, default 2 — cycles from command accept to content update; legal range 1..15.

Ports:
- clk  in  1  — the single clock.
- rst  in  1  — asynchronous, active-high reset.
- data_in  in  HALF_W  — data bus value.
- addr_in  in  2*HALF_W  — address bus value.
- ld_hi  in  1  — load high half from data_in.
- ld_lo  in  1  — load low half from data_in.
- ld_addr  in  1  — load the full word from addr_in.
- inc  in  1  — increment the full word.
- sel  in  1  — drive content onto the address bus.
- addr_out  out  2*HALF_W  — content when sel=1, else 0.
- addr_oe  out  1  — equals sel.
- content  out  2*HALF_W  — current register content, always visible.
- busy  out  1  — settle in progress.
- carry  out  1  — one-cycle pulse on increment wrap.
- overrun  out  1  — sticky: a command arrived while busy.
- led_ld  out  1  — OR of all accepted-command strobes (ld_hi, ld_lo, ld_addr, inc) while busy.
- led_sel  out  1  — equals sel.

## Operation
- States:
  - IDLE: busy=0.
  - SETTLE: busy=1; a down-counter runs from SETTLE-1 to 0.
- Accept rule: in IDLE, any of ld_hi, ld_lo, ld_addr or inc high at a rising edge is accepted.
  - Operands (data_in, addr_in, current content) and the command type are latched at that edge.
  - The FSM enters SETTLE.
- Command priority at accept:
  - ld_addr beats ld_hi/ld_lo, which beat inc.
  - ld_hi and ld_lo together load both halves with the same data_in value.
  - A lower-priority command asserted alongside a higher one is silently discarded; it does not set overrun.
- Commit: when the counter reaches 0, content takes the new value at that edge and the FSM returns to IDLE.
- Increment: content = (content + 1) mod 2^(2*HALF_W). carry pulses high for the commit cycle only when content wraps from all-ones to 0.
- While busy:
  - Any ld_* or inc high is ignored and sets overrun.
  - overrun stays set until rst.
- sel is independent of the FSM. While busy, addr_out shows the pre-command content; the new value appears from the commit cycle onward.
- Reset values:
  - content = 0, addr_out = 0, busy = 0, carry = 0, overrun = 0, led_ld = 0, state = IDLE.
  - addr_oe and led_sel follow sel combinationally.
- Reset mid-settle aborts the pending command; content becomes 0 and nothing is committed after release.

## Timing
- Command accepted at edge T → busy high from T through T+SETTLE (exclusive) → content updated at edge T+SETTLE.
- busy falls in the same cycle content changes.
- A new command can be accepted at edge T+SETTLE+1 at the earliest. A command held high across edge T+SETTLE is treated as busy-time input and sets overrun.
- Throughput is one command per SETTLE+1 cycles.
- addr_out and content are registered/combinational from the content register only; there is no combinational path from data_in or addr_in.
- carry is registered and aligned with the content update.

## Test plan
- HALF_W=8, SETTLE=2:
  - Reset.
  - ld_hi with data_in=0x12 at T0; ld_lo with data_in=0x34 at T3.
  - Expect content=0x1200 at T2 and 0x1234 at T5.
  - Expect busy high during T0–T1 and T3–T4.
- ld_addr with addr_in=0xFFFF, then inc:
  - Content reaches 0x0000 at commit.
  - carry is high for exactly one cycle.
  - A second inc gives 0x0001 with carry=0.
- ld_addr (0xBEEF) and ld_lo (0x55) asserted together:
  - Content becomes 0xBEEF.
  - overrun stays 0.
- inc pulsed during busy:
  - Ignored; the committed value is unaffected.
  - overrun goes to 1 and stays set until rst.
- sel=1 throughout a ld_addr 0x00A0 over content 0x1234:
  - addr_out=0x1234 until the commit edge, then 0x00A0.
  - With sel=0, addr_out=0 and addr_oe=0.
- rst asserted one cycle after accepting ld_addr 0x4321:
  - content=0 and busy=0 immediately.
  - content remains 0 after rst is released.
